// File: rtl/i2s_rx_10xe_deser_pkg.sv
// i2s_rx_10xe_deser_pkg: shared widths, FIFO depth, RX FSM states and channel ids for the I2S RX deserializer
package i2s_rx_10xe_deser_pkg;
  localparam int AXI_STREAM_DATA_WIDTH = 32;
  localparam int AXI_STREAM_TID_WIDTH = 3;
  localparam int SAMPLE_WIDTH = 24;
  localparam int RX_FIFO_DEPTH = 4;
  typedef logic [AXI_STREAM_DATA_WIDTH-1:0] axi_stream_data;
  typedef logic [AXI_STREAM_TID_WIDTH-1:0] axi_stream_tid;
  typedef enum logic [1:0] {IDLE, ARM, SHIFT, WAIT_LR} i2s_rx_state_e;
  localparam axi_stream_tid CH_LEFT = 3'd0;
  localparam axi_stream_tid CH_RIGHT = 3'd1;
endpackage

// File: rtl/i2s_rx_10xe_deser_if.sv
// i2s_rx_10xe_deser_if: AXI-Stream sample bus (tdata, tid, tvalid, tready); master drives data, slave drives tready
interface i2s_rx_10xe_deser_if;
  import i2s_rx_10xe_deser_pkg::*;
  axi_stream_data tdata;
  axi_stream_tid tid;
  logic tvalid;
  logic tready;
  modport master (output tdata, tid, tvalid, input tready);
  modport slave (input tdata, tid, tvalid, output tready);
endinterface

// File: rtl/i2s_rx_10xe_deser_fifo.sv
// i2s_rx_10xe_deser_fifo: synchronous FIFO with full/empty flags; a push is accepted when full if a pop happens on the same cycle
//   aud_mclk/aud_mrst clock and async reset; push/din write side; pop/dout read side (dout shows the head entry)
module i2s_rx_10xe_deser_fifo #(
  parameter int W = 35,
  parameter int DEPTH = 4
) (
  input  logic         aud_mclk,
  input  logic         aud_mrst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge aud_mclk or posedge aud_mrst)
    if (aud_mrst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/i2s_rx_10xe_deser.sv
// i2s_rx_10xe_deser: oversampling I2S receiver that packs left/right samples into AXI-Stream words through a small FIFO
//   aud_mclk/aud_mrst: sole clock, async active-high reset; rx_en: capture enable
//   sclk_in/lrclk_in/sdata_in: asynchronous I2S bus; m_axis: tdata = sample in [SAMPLE_WIDTH+3:4], tid = channel
//   ovf_flag/ovf_clr: sticky overflow and its clear; short_frame: one-cycle pulse per truncated word
//   I2S_RX_OVF_CNT_EN adds ovf_count, a saturating count of dropped words
module i2s_rx_10xe_deser #(
  parameter int SAMPLE_WIDTH = i2s_rx_10xe_deser_pkg::SAMPLE_WIDTH,
  parameter int FIFO_DEPTH = i2s_rx_10xe_deser_pkg::RX_FIFO_DEPTH
) (
  input  logic aud_mclk,
  input  logic aud_mrst,
  input  logic rx_en,
  input  logic sclk_in,
  input  logic lrclk_in,
  input  logic sdata_in,
  i2s_rx_10xe_deser_if.master m_axis,
  output logic ovf_flag,
  input  logic ovf_clr,
  output logic short_frame
`ifdef I2S_RX_OVF_CNT_EN
  , output logic [7:0] ovf_count
`endif
);
  import i2s_rx_10xe_deser_pkg::*;
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int FW = AXI_STREAM_TID_WIDTH + AXI_STREAM_DATA_WIDTH;
  i2s_rx_state_e state, state_n;
  logic [1:0] sclk_s, lr_s, sd_s;
  logic sclk_q, lr_prev, lr_init, rise, lr_change, emit, short_n, push, full, empty, pop, drop;
  logic [SAMPLE_WIDTH-1:0] shreg, aligned;
  logic [CW-1:0] cnt;
  axi_stream_tid ch;
  logic [FW-1:0] word, dout;
  // lr_init keeps the first sclk rise after reset from being mistaken for a word boundary
  assign rise = sclk_s[1] & ~sclk_q;
  assign lr_change = rise & lr_init & (lr_s[1] != lr_prev);
  // a truncated word keeps its captured bits MSB-aligned with zeros below
  assign aligned = shreg << (CW'(SAMPLE_WIDTH) - cnt);
  always_ff @(posedge aud_mclk or posedge aud_mrst)
    if (aud_mrst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    emit = 1'b0;
    short_n = 1'b0;
    if (!rx_en) state_n = IDLE;
    else if (rise)
      unique case (state)
        IDLE: state_n = lr_change ? ARM : IDLE;
        ARM: state_n = SHIFT;
        SHIFT: begin
          emit = lr_change;
          short_n = lr_change;
          state_n = lr_change ? ARM : cnt == CW'(SAMPLE_WIDTH - 1) ? WAIT_LR : SHIFT;
        end
        WAIT_LR: begin
          emit = lr_change;
          state_n = lr_change ? ARM : WAIT_LR;
        end
      endcase
  end
  always_ff @(posedge aud_mclk or posedge aud_mrst)
    if (aud_mrst) begin
      sclk_s <= '0;
      lr_s <= '0;
      sd_s <= '0;
      sclk_q <= 1'b0;
      lr_prev <= 1'b0;
      lr_init <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      ch <= CH_LEFT;
      push <= 1'b0;
      word <= '0;
      short_frame <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk_in};
      lr_s <= {lr_s[0], lrclk_in};
      sd_s <= {sd_s[0], sdata_in};
      sclk_q <= sclk_s[1];
      push <= emit;
      short_frame <= short_n;
      if (rise) begin
        lr_prev <= lr_s[1];
        lr_init <= 1'b1;
      end
      if (lr_change) ch <= lr_s[1] ? CH_RIGHT : CH_LEFT;
      if (emit) word <= {ch, AXI_STREAM_DATA_WIDTH'({aligned, 4'b0})};
      if (rise && state == ARM) begin
        shreg <= SAMPLE_WIDTH'(sd_s[1]);
        cnt <= CW'(1);
      end else if (rise && state == SHIFT && !lr_change) begin
        shreg <= {shreg[SAMPLE_WIDTH-2:0], sd_s[1]};
        cnt <= cnt + CW'(1);
      end
    end
  assign pop = m_axis.tvalid & m_axis.tready;
  assign drop = push & full & ~pop;
  assign m_axis.tvalid = ~empty;
  assign {m_axis.tid, m_axis.tdata} = dout;
  i2s_rx_10xe_deser_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aud_mclk(aud_mclk),
    .aud_mrst(aud_mrst),
    .push(push),
    .din(word),
    .pop(pop),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  // a drop sets the flag even when a clear arrives on the same cycle
  always_ff @(posedge aud_mclk or posedge aud_mrst)
    if (aud_mrst) ovf_flag <= 1'b0;
    else ovf_flag <= drop | (ovf_flag & ~ovf_clr);
`ifdef I2S_RX_OVF_CNT_EN
  always_ff @(posedge aud_mclk or posedge aud_mrst)
    if (aud_mrst) ovf_count <= '0;
    else ovf_count <= ovf_clr ? 8'(drop) : (drop && ovf_count != 8'hFF) ? ovf_count + 8'd1 : ovf_count;
`endif
endmodule

// File: tb/tb_i2s_rx_10xe_deser.sv
// tb_i2s_rx_10xe_deser: drives I2S frames into i2s_rx_10xe_deser and checks the AXI-Stream words against a frame-level model
module tb_i2s_rx_10xe_deser;
  import i2s_rx_10xe_deser_pkg::*;
  localparam int SW = 24;
  localparam int DEPTH = 4;
  localparam int HALF = 23;
  logic aud_mclk = 1'b0, aud_mrst = 1'b1, rx_en = 1'b1;
  logic sclk_in = 1'b1, lrclk_in = 1'b1, sdata_in = 1'b0;
  logic ovf_flag, ovf_clr = 1'b0, short_frame;
`ifdef I2S_RX_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif
  i2s_rx_10xe_deser_if bus();
  i2s_rx_10xe_deser dut (
    .aud_mclk(aud_mclk),
    .aud_mrst(aud_mrst),
    .rx_en(rx_en),
    .sclk_in(sclk_in),
    .lrclk_in(lrclk_in),
    .sdata_in(sdata_in),
    .m_axis(bus),
    .ovf_flag(ovf_flag),
    .ovf_clr(ovf_clr),
    .short_frame(short_frame)
`ifdef I2S_RX_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );
  always #5 aud_mclk = ~aud_mclk;
  int n_checks = 0, n_fail = 0, exp_drop = 0, exp_short = 0, short_seen = 0;
  int rdy_mode = 1;
  logic cur_lr = 1'b1, armed = 1'b0, same_pop = 1'b0;
  logic [34:0] exp_q[$];
  logic [23:0] prev_s = '0;
  int prev_n = 0, prev_len = 0;
  logic prev_lr = 1'b0;
  // tready: 0 = held low, 1 = held high, 2 = random, 3 = high only on the cycle a truncated word is pushed
  initial forever begin
    @(negedge aud_mclk);
    bus.tready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 3 ? short_frame : rdy_mode == 1;
  end
  always @(negedge aud_mclk) begin
    logic [34:0] e;
    #2;
    if (short_frame) short_seen++;
    if (!aud_mrst && bus.tvalid && bus.tready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word got %h expected none", {bus.tid, bus.tdata});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        assert ({bus.tid, bus.tdata} === e) else begin
          n_fail++;
          $error("FAIL word got %h expected %h", {bus.tid, bus.tdata}, e);
        end
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // the word a completed slot should produce: top prev_n bits of the sample, channel from its lrclk level
  task automatic model_emit();
    logic [23:0] v;
    logic [34:0] w;
    v = prev_s & ~((24'h1 << (SW - prev_n)) - 24'h1);
    w = {prev_lr ? 3'd1 : 3'd0, 4'h0, v, 4'h0};
    if (prev_len - 1 < SW) exp_short++;
    if (exp_q.size() >= DEPTH && !same_pop) exp_drop++;
    else exp_q.push_back(w);
  endtask
  task automatic send_bit(input logic lr, input logic d);
    sclk_in = 1'b0;
    lrclk_in = lr;
    sdata_in = d;
    #HALF;
    sclk_in = 1'b1;
    #HALF;
  endtask
  // one I2S slot: bit 0 is the one-bit delay after the lrclk edge, then n sample bits MSB first, then zeros
  task automatic send_slot(input logic [23:0] s, input int n, input int len);
    cur_lr = ~cur_lr;
    if (armed && rx_en) model_emit();
    armed = rx_en;
    prev_s = s;
    prev_n = n;
    prev_len = len;
    prev_lr = cur_lr;
    for (int i = 0; i < len; i++) send_bit(cur_lr, (i >= 1 && i <= n) ? s[SW-i] : 1'b0);
  endtask
  task automatic restart();
    @(negedge aud_mclk);
    rx_en = 1'b0;
    armed = 1'b0;
    repeat (4) @(negedge aud_mclk);
    rx_en = 1'b1;
  endtask
  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge aud_mclk);
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    repeat (3) @(negedge aud_mclk);
    #1;
    check("rst_tvalid", 64'(bus.tvalid), 64'd0);
    check("rst_tdata", 64'(bus.tdata), 64'd0);
    check("rst_tid", 64'(bus.tid), 64'd0);
    check("rst_ovf", 64'(ovf_flag), 64'd0);
    check("rst_short", 64'(short_frame), 64'd0);
`ifdef I2S_RX_OVF_CNT_EN
    check("rst_ovf_count", 64'(ovf_count), 64'd0);
`endif
    @(negedge aud_mclk);
    aud_mrst = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    send_slot(24'hA5A5A5, 24, 32);
    send_slot(24'h5A5A5A, 24, 32);
    send_slot(24'h0, 0, 2);
    wait_drain();
    restart();
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) send_slot(24'($urandom), 24, 32);
    send_slot(24'h0, 0, 2);
    repeat (20) @(negedge aud_mclk);
    check("ovf_flag_set", 64'(ovf_flag), 64'd1);
    check("ovf_tvalid_held", 64'(bus.tvalid), 64'd1);
    check("ovf_drops", 64'(exp_drop), 64'd2);
`ifdef I2S_RX_OVF_CNT_EN
    check("ovf_count", 64'(ovf_count), 64'(exp_drop));
`endif
    ovf_clr = 1'b1;
    @(negedge aud_mclk);
    ovf_clr = 1'b0;
    exp_drop = 0;
    check("ovf_flag_clr", 64'(ovf_flag), 64'd0);
`ifdef I2S_RX_OVF_CNT_EN
    check("ovf_count_clr", 64'(ovf_count), 64'd0);
`endif
    restart();
    rdy_mode = 1;
    wait_drain();
    send_slot(24'hFFFF00, 16, 17);
    send_slot(24'($urandom), 24, 32);
    send_slot(24'h0, 0, 2);
    wait_drain();
    check("short_pulses", 64'(short_seen), 64'(exp_short));
    restart();
    send_slot(24'h123456, 24, 32);
    fork
      send_slot(24'h654321, 24, 32);
      begin
        #(2 * HALF * 10);
        rx_en = 1'b0;
        armed = 1'b0;
      end
    join
    check("dis_tvalid", 64'(bus.tvalid), 64'd0);
    fork
      send_slot(24'hABCDEF, 24, 32);
      begin
        #(2 * HALF * 10);
        rx_en = 1'b1;
      end
    join
    send_slot(24'h13579B, 24, 32);
    send_slot(24'h2468AC, 24, 32);
    send_slot(24'h0, 0, 2);
    wait_drain();
    restart();
    rdy_mode = 0;
    send_slot(24'h0F0F0F, 24, 32);
    fork
      send_slot(24'hF0F0F0, 24, 32);
      begin
        #(2 * HALF * 12);
        check("pre_rst_tvalid", 64'(bus.tvalid), 64'd1);
        aud_mrst = 1'b1;
        #1;
        check("mrst_tvalid", 64'(bus.tvalid), 64'd0);
        check("mrst_tdata", 64'(bus.tdata), 64'd0);
        check("mrst_ovf", 64'(ovf_flag), 64'd0);
        exp_q.delete();
        armed = 1'b0;
        @(negedge aud_mclk);
        aud_mrst = 1'b0;
      end
    join
    rdy_mode = 1;
    send_slot(24'h3C3C3C, 24, 32);
    send_slot(24'hC3C3C3, 24, 32);
    send_slot(24'h0, 0, 2);
    wait_drain();
    restart();
    rdy_mode = 3;
    for (int i = 0; i < 4; i++) send_slot(24'($urandom), 24, 32);
    send_slot(24'hBEEF00, 16, 17);
    same_pop = 1'b1;
    send_slot(24'h0, 0, 2);
    same_pop = 1'b0;
    repeat (20) @(negedge aud_mclk);
    check("full_pushpop_ovf", 64'(ovf_flag), 64'd0);
    check("full_pushpop_left", 64'(exp_q.size()), 64'(DEPTH));
`ifdef I2S_RX_OVF_CNT_EN
    check("full_pushpop_count", 64'(ovf_count), 64'd0);
`endif
    restart();
    rdy_mode = 1;
    wait_drain();
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) begin
      int n, len;
      n = $urandom_range(16, 24);
      len = $urandom_range(n + 1, 32);
      send_slot(24'($urandom), n, len);
    end
    send_slot(24'h0, 0, 2);
    wait_drain();
    check("rand_short_pulses", 64'(short_seen), 64'(exp_short));
    check("rand_ovf", 64'(ovf_flag), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
